// File: rtl/i2c_line_conditioner_pkg.sv
// Shared constants for the I2C pad conditioning front end.
// Idle bus level and default filter sizing used by the line filters and the top.
package i2c_line_conditioner_pkg;

    localparam logic I2C_IDLE_LEVEL   = 1'b1;
    localparam int   FILTER_CYCLES_DEF = 3;
    localparam int   CNT_W_DEF         = 4;

endpackage

// File: rtl/i2c_line_conditioner_filter.sv
// One I2C line: two-flop synchronizer, stability-count deglitcher and edge decode.
// The filtered level only moves after the synchronized input disagrees for FILTER_CYCLES edges.
module i2c_line_filter
    import i2c_line_conditioner_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             filt;
    logic             filt_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1     <= I2C_IDLE_LEVEL;
            s2     <= I2C_IDLE_LEVEL;
            filt   <= I2C_IDLE_LEVEL;
            filt_d <= I2C_IDLE_LEVEL;
            cnt    <= '0;
        end else begin
            s1     <= pin;
            s2     <= s1;
            filt_d <= filt;
            // A return to the accepted level discards any partial count.
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = filt;
    assign rise  = filt & ~filt_d;
    assign fall  = ~filt & filt_d;

endmodule

// File: rtl/i2c_line_conditioner.sv
// I2C pad front end: deglitched SDA/SCL levels, edge strobes and START/STOP detect.
// START/STOP require SCL high both before and after the SDA edge.
module i2c_line_conditioner
    import i2c_line_conditioner_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic SDA_in,
    input  logic SCL_in,
    output logic SDA_sync,
    output logic SCL_sync,
    output logic SDA_rise,
    output logic SDA_fall,
    output logic SCL_rise,
    output logic SCL_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_high_stable;

    i2c_line_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .CNT_W         (CNT_W)
    ) u_sda (
        .clk   (clk),
        .n_rst (n_rst),
        .pin   (SDA_in),
        .level (SDA_sync),
        .rise  (SDA_rise),
        .fall  (SDA_fall)
    );

    i2c_line_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .CNT_W         (CNT_W)
    ) u_scl (
        .clk   (clk),
        .n_rst (n_rst),
        .pin   (SCL_in),
        .level (SCL_sync),
        .rise  (SCL_rise),
        .fall  (SCL_fall)
    );

    // Filtered SCL high now and not just risen means it was high on the previous cycle too.
    assign scl_high_stable = SCL_sync & ~SCL_rise;

    assign start_det = SDA_fall & scl_high_stable;
    assign stop_det  = SDA_rise & scl_high_stable;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Scoreboard bench for i2c_line_conditioner with FILTER_CYCLES = 3.
// Stimulus queues expected strobe events; a monitor compares every strobe the DUT shows.
module tb_i2c_line_conditioner;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic SDA_in = 1'b1;
    logic SCL_in = 1'b1;
    logic SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall, start_det, stop_det;

    localparam int LAT = 5;   // drive at negedge before edge k -> visible after edge k+4

    localparam logic [5:0] V_SDA_R = 6'b100000;
    localparam logic [5:0] V_SDA_F = 6'b010000;
    localparam logic [5:0] V_SCL_R = 6'b001000;
    localparam logic [5:0] V_SCL_F = 6'b000100;
    localparam logic [5:0] V_START = 6'b000010;
    localparam logic [5:0] V_STOP  = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
        logic       sda;
        logic       scl;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   drv_cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [5:0] strobes;

    i2c_line_conditioner #(.FILTER_CYCLES(3), .CNT_W(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .SDA_in    (SDA_in),
        .SCL_in    (SCL_in),
        .SDA_sync  (SDA_sync),
        .SCL_sync  (SCL_sync),
        .SDA_rise  (SDA_rise),
        .SDA_fall  (SDA_fall),
        .SCL_rise  (SCL_rise),
        .SCL_fall  (SCL_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign strobes = {SDA_rise, SDA_fall, SCL_rise, SCL_fall, start_det, stop_det};

    // Monitor: checks every strobe cycle against the queue and flags expected events that never came.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: expected strobes %b at cycle %0d, not observed by cycle %0d",
                     q[0].vec, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (strobes != 6'b0) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: got %b at cycle %0d, required none", strobes, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.vec != strobes || e.sda != SDA_sync || e.scl != SCL_sync) begin
                    n_bad++;
                    $display("FAIL strobe_event: got cyc=%0d strobes=%b sda=%b scl=%b, required cyc=%0d strobes=%b sda=%b scl=%b",
                             cyc, strobes, SDA_sync, SCL_sync, e.cyc, e.vec, e.sda, e.scl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_pins(input logic sda, input logic scl);
        @(negedge clk);
        SDA_in  = sda;
        SCL_in  = scl;
        drv_cyc = cyc;
    endtask

    task automatic expect_ev(input int c, input logic [5:0] v, input logic sda, input logic scl);
        exp_t e;
        e.cyc = c; e.vec = v; e.sda = sda; e.scl = scl;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with idle pins
        #12;
        chk("reset_levels", {6'b0, SDA_sync, SCL_sync}, 8'h03);
        chk("reset_strobes", {2'b0, strobes}, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        idle(20);
        chk("idle_levels", {6'b0, SDA_sync, SCL_sync}, 8'h03);

        // START: SDA falls with SCL high
        set_pins(1'b0, 1'b1);
        expect_ev(drv_cyc + LAT, V_SDA_F | V_START, 1'b0, 1'b1);
        idle(LAT - 1);
        chk("sda_before_latency", {7'b0, SDA_sync}, 8'h01);
        idle(6);

        // STOP: SDA rises with SCL high
        set_pins(1'b1, 1'b1);
        expect_ev(drv_cyc + LAT, V_SDA_R | V_STOP, 1'b1, 1'b1);
        idle(10);

        // 2-cycle low glitch is discarded
        set_pins(1'b0, 1'b1);
        idle(1);
        set_pins(1'b1, 1'b1);
        idle(10);
        chk("glitch2_level", {7'b0, SDA_sync}, 8'h01);

        // 3-cycle low glitch passes: one fall then one rise
        set_pins(1'b0, 1'b1);
        expect_ev(drv_cyc + LAT, V_SDA_F | V_START, 1'b0, 1'b1);
        expect_ev(drv_cyc + LAT + 3, V_SDA_R | V_STOP, 1'b1, 1'b1);
        idle(2);
        set_pins(1'b1, 1'b1);
        idle(12);

        // SDA toggles while SCL low: edge strobes only
        set_pins(1'b1, 1'b0);
        expect_ev(drv_cyc + LAT, V_SCL_F, 1'b1, 1'b0);
        idle(10);
        set_pins(1'b0, 1'b0);
        expect_ev(drv_cyc + LAT, V_SDA_F, 1'b0, 1'b0);
        idle(10);
        set_pins(1'b1, 1'b0);
        expect_ev(drv_cyc + LAT, V_SDA_R, 1'b1, 1'b0);
        idle(10);
        set_pins(1'b1, 1'b1);
        expect_ev(drv_cyc + LAT, V_SCL_R, 1'b1, 1'b1);
        idle(10);

        // Simultaneous transitions: both edges, no START/STOP
        set_pins(1'b0, 1'b0);
        expect_ev(drv_cyc + LAT, V_SDA_F | V_SCL_F, 1'b0, 1'b0);
        idle(10);
        set_pins(1'b1, 1'b1);
        expect_ev(drv_cyc + LAT, V_SDA_R | V_SCL_R, 1'b1, 1'b1);
        idle(10);

        // Reset while the SDA counter sits at 2
        set_pins(1'b0, 1'b1);
        idle(LAT - 1);
        chk("midfilter_level", {7'b0, SDA_sync}, 8'h01);
        n_rst  = 1'b0;
        SDA_in = 1'b1;
        #1;
        chk("midfilter_reset", {6'b0, SDA_sync, SCL_sync}, 8'h03);
        idle(2);
        n_rst = 1'b1;
        idle(15);
        chk("midfilter_after", {6'b0, SDA_sync, SCL_sync}, 8'h03);

        // Asynchronous reset while SDA_sync is low
        set_pins(1'b0, 1'b1);
        expect_ev(drv_cyc + LAT, V_SDA_F | V_START, 1'b0, 1'b1);
        idle(LAT + 2);
        chk("low_before_reset", {7'b0, SDA_sync}, 8'h00);
        #3;
        n_rst  = 1'b0;
        SDA_in = 1'b1;
        #1;
        chk("async_reset_level", {7'b0, SDA_sync}, 8'h01);
        chk("async_reset_strobes", {2'b0, strobes}, 8'h00);
        idle(2);
        n_rst = 1'b1;
        idle(20);
        chk("post_reset_levels", {6'b0, SDA_sync, SCL_sync}, 8'h03);

        while (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_event: expected strobes %b at cycle %0d never seen", q[0].vec, q[0].cyc);
            void'(q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_line_conditioner.md
Name: i2c_line_conditioner

Overview:
Front-end conditioning stage for the I2C slave/master pins. It synchronizes raw SDA/SCL pad inputs and rejects short glitches with a per-line stability counter. It produces the clean SDA_sync/SCL_sync levels that feed the bus busy tester and the I2C controllers. It also produces one-cycle edge strobes and START/STOP detect strobes for downstream shift logic.

Parameters:
FILTER_CYCLES, 3, consecutive synchronized cycles a new level must persist before the filtered output accepts it; legal range 1..15.
CNT_W, 4, counter width; must satisfy 2^CNT_W > FILTER_CYCLES.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
SDA_in  input  1  raw SDA pad input (asynchronous)
SCL_in  input  1  raw SCL pad input (asynchronous)
SDA_sync  output  1  synchronized, deglitched SDA level
SCL_sync  output  1  synchronized, deglitched SCL level
SDA_rise  output  1  one-cycle pulse: SDA_sync went 0->1
SDA_fall  output  1  one-cycle pulse: SDA_sync went 1->0
SCL_rise  output  1  one-cycle pulse: SCL_sync went 0->1
SCL_fall  output  1  one-cycle pulse: SCL_sync went 1->0
start_det  output  1  one-cycle pulse: START condition
stop_det  output  1  one-cycle pulse: STOP condition

Behaviour:
- Single clock clk. Reset n_rst is asynchronous and active-low. All state resets asynchronously.
- Reset values model an idle bus:
  - sync flops s1/s2 = 1
  - filtered level filt = 1
  - previous filtered level filt_d = 1
  - counter = 0
- Output reset values: SDA_sync = SCL_sync = 1; all pulse outputs = 0.
- Synchronizer: 2-flop chain per line, s1 <= pin, s2 <= s1. There is no logic between the two flops.
- Filter, evaluated per line on each clk edge:
  - if s2 == filt: cnt <= 0
  - else if cnt == FILTER_CYCLES-1: filt <= s2, cnt <= 0
  - else: cnt <= cnt+1
- Filter consequences:
  - Any s2 pulse shorter than FILTER_CYCLES cycles is discarded.
  - A return to filt mid-count clears cnt; the count does not resume.
- Latency: a pin level sampled at edge k appears on x_sync after edge k+1+FILTER_CYCLES. That is FILTER_CYCLES+2 edges including the sampling edge.
- filt_d <= filt every cycle. x_sync = filt directly, with no extra register.
- Edge strobes are combinational decodes of registered state only:
  - rise = filt & ~filt_d
  - fall = ~filt & filt_d
  - Each strobe is exactly one cycle wide. It coincides with the first cycle of the new x_sync level.
- start_det = SDA_fall & SCL_filt & SCL_filt_d, i.e. SCL high both before and after the SDA edge.
- stop_det = SDA_rise & SCL_filt & SCL_filt_d.
- Simultaneous SDA and SCL filtered transitions in the same cycle:
  - the edge strobes for both lines fire
  - start_det and stop_det stay 0
- SDA edge while SCL low: edge strobe only; no start_det or stop_det.
- start_det and stop_det are mutually exclusive by construction.
- Reset asserted mid-filter: all state returns to idle immediately. On release, outputs read 1 and no edge, START or STOP strobes fire.
- If the pins are 0 at reset release, falls are reported FILTER_CYCLES+2 edges later. This is correct: downstream treats it as bus activity.

Decomposition:
- Shared I2C package holds:
  - I2C_IDLE_LEVEL = 1'b1
  - default FILTER_CYCLES
  - CNT_W helper constant
- One natural sub-module, i2c_line_filter. It contains the synchronizer, counter, filt and filt_d for one line. It outputs level, rise and fall, and is instantiated twice (SDA, SCL).
- START/STOP decode lives in the top module.

Test Plan:
- Reset with pins at 1, release, hold 20 cycles -> SDA_sync = SCL_sync = 1; all strobes 0 throughout.
- FILTER_CYCLES=3: drive SDA_in 1->0 before edge k, SCL high -> SDA_sync falls after edge k+4; SDA_fall and start_det pulse high for exactly that one cycle.
- SDA_in low glitch of 2 cycles (FILTER_CYCLES=3), then 3-cycle glitch -> first is ignored (no SDA_fall, cnt returns to 0); second produces exactly one SDA_fall.
- SCL high, SDA 0->1 -> stop_det pulses once. Then SCL low, toggle SDA -> SDA_rise/SDA_fall pulse, start_det and stop_det stay 0.
- Drive SDA_in and SCL_in 1->0 on the same cycle -> SDA_fall and SCL_fall pulse on the same cycle; start_det = 0.
- Assert n_rst while SDA counter is at 2 -> SDA_sync = 1 immediately (asynchronously). After release with SDA_in = 1, no strobes occur.
